// File: rtl/fullAdder2.sv
// One-bit full-adder cell shared by the lab datapaths.
// Pure combinational: sum and carry-out of a + b + cin.
module fullAdder2 (
  output logic cout,
  output logic s,
  input  logic a,
  input  logic b,
  input  logic cin
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: sequences one full-adder cell over WIDTH cycles, LSB first,
// with a start/busy/done handshake and registered sum/cout.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_c;
  logic             accept, last_bit;

  fullAdder2 u_fa (
    .cout (fa_c),
    .s    (fa_s),
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry)
  );

  // Start is only honoured when no operation is in flight.
  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign last_bit = (state == RUN) && (cnt == LAST_BIT);

  // New bit enters at the MSB; after WIDTH shifts bit 0 of the sum sits at bit 0.
  assign res_nxt  = (res_sr >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  // Handshake outputs decode the state register only, so they cannot glitch from inputs.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      state <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: default assigned first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST_BIT) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every datapath register is reset, so an aborted operation leaves no residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      if (accept) begin
        a_sr  <= a;
        b_sr  <= b;
        carry <= cin;
        cnt   <= '0;
      end else if (state == RUN) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        res_sr <= res_nxt;
        carry  <= fa_c;
        cnt    <= cnt + CW'(1);
      end
      if (last_bit) begin
        sum  <= res_nxt;
        cout <= fa_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl at WIDTH=8, plus a WIDTH=1 build,
// using a scoreboard queue of {cout,sum} expectations.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  logic         start1;
  logic [0:0]   a1, b1, sum1;
  logic         cin1, busy1, done1, cout1;

  int checks   = 0;
  int failures = 0;
  logic [W:0] exp_q[$];

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
    a     = ia;
    b     = ib;
    cin   = ic;
    start = 1'b1;
    exp_q.push_back({1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, ic});
  endtask

  // Advance from the start cycle to the done pulse, then check timing and result.
  task automatic run_to_done(input string tag);
    int   cycles = 0;
    int   busy_n = 0;
    bit   seen   = 0;
    logic [W:0] exp;
    for (int i = 0; i < W + 4; i++) begin
      tick();
      if (i == 0) start = 1'b0;
      cycles++;
      if (busy) busy_n++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(cycles), 32'(W + 1));
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(W));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check({tag, "_result"}, 32'({cout, sum}), 32'(exp));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    tick();
    tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum_cout", 32'({cout, sum}), 32'd0);
    check("reset_w1_outputs", 32'({busy1, done1, cout1, sum1}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic operations, including carry-out corner cases.
    issue(8'h5A, 8'h3C, 1'b0); run_to_done("add_5a_3c");
    issue(8'hFF, 8'h01, 1'b0); run_to_done("add_ff_01");
    issue(8'hFF, 8'hFF, 1'b1); run_to_done("add_ff_ff_c1");
    tick();
    check("held_after_done", 32'({cout, sum}), 32'h1FF);
    check("idle_after_done", 32'({busy, done}), 32'd0);

    // Start held through RUN, operands changed mid-run: both must be ignored.
    issue(8'h01, 8'h01, 1'b0);
    for (int k = 1; k <= W; k++) begin
      tick();
      check("hold_busy", 32'(busy), 32'd1);
      if (k == 1) check("hold_prev_result", 32'({cout, sum}), 32'h1FF);
      if (k == 3) begin a = 8'h10; b = 8'h10; end
      if (k == W) start = 1'b0;
    end
    tick();
    check("hold_done", 32'(done), 32'd1);
    check("hold_result", 32'({cout, sum}), 32'({1'b0, 8'h02}));
    void'(exp_q.pop_front());
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_single_done", 32'({busy, done}), 32'd0);
    end

    // Back-to-back: second start lands in the DONE cycle.
    issue(8'h22, 8'h11, 1'b0); run_to_done("b2b_first");
    issue(8'h0F, 8'h01, 1'b0);
    tick();
    check("b2b_busy_resumes", 32'(busy), 32'd1);
    check("b2b_prev_held", 32'({cout, sum}), 32'h033);
    start = 1'b0;
    for (int k = 2; k <= W; k++) tick();
    check("b2b_busy_last", 32'(busy), 32'd1);
    tick();
    check("b2b_second_done", 32'(done), 32'd1);
    check("b2b_result", 32'({cout, sum}), 32'h010);
    void'(exp_q.pop_front());

    // Reset mid-run aborts immediately and clears the held result.
    tick();
    issue(8'h33, 8'h44, 1'b1);
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", 32'({busy, done, cout, sum}), 32'd0);
    void'(exp_q.pop_back());
    for (int k = 0; k < W + 2; k++) begin
      tick();
      if (k == 2) rst_n = 1'b1;
      check("abort_no_done", 32'(done), 32'd0);
    end
    issue(8'hA5, 8'h5A, 1'b1); run_to_done("after_abort");

    // WIDTH=1 build: one RUN cycle, done at T+2.
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("w1_busy", 32'({busy1, done1}), 32'b10);
    tick();
    check("w1_done", 32'({busy1, done1}), 32'b01);
    check("w1_result_111", 32'({cout1, sum1}), 32'b11);
    a1 = 1'b0; b1 = 1'b1; cin1 = 1'b0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    check("w1_done_2", 32'(done1), 32'd1);
    check("w1_result_010", 32'({cout1, sum1}), 32'b01);

    // Random operations against the a+b+cin reference.
    for (int n = 0; n < 1000; n++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
      run_to_done("rand");
    end
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
